// File: rtl/icache_param_pkg.sv
// Shared definitions for the parametrised instruction cache.
// Holds the FSM state encoding, the fetch-enable polarity and a constant clog2 helper.
// No logic of its own; imported by icache_param and icache_line_array.
package icache_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_FILL   = 2'd2
    } state_t;

    // Fetch enable is active-low, the same polarity as rom_ce_n.
    localparam logic CE_ENABLE = 1'b0;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << res) < value) res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped icache: combinational read of one word.
// Latency: read is same-cycle; whole-line write and flush take effect at the next edge.
// No backpressure: write is accepted every cycle wr_en is high; flush wins over a write.
// Ports: rd_idx/rd_off -> rd_vld/rd_tag/rd_dat; wr_en/wr_idx/wr_tag/wr_line; flush_i clears valid.
module icache_line_array
    import icache_param_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 26,
    parameter int IDX_W      = 4,
    parameter int OFF_SZ     = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_i,
    input  logic [IDX_W-1:0]                  rd_idx,
    input  logic [OFF_SZ-1:0]                 rd_off,
    output logic                              rd_vld,
    output logic [TAG_W-1:0]                  rd_tag,
    output logic [DATA_W-1:0]                 rd_dat,
    input  logic                              wr_en,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic [TAG_W-1:0]                  wr_tag,
    input  logic [LINE_WORDS-1:0][DATA_W-1:0] wr_line
);

    logic [LINES-1:0]                  valid;
    logic [TAG_W-1:0]                  tag_ram  [LINES];
    logic [LINE_WORDS-1:0][DATA_W-1:0] data_ram [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush_i) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en && !flush_i) begin
            tag_ram[wr_idx]  <= wr_tag;
            data_ram[wr_idx] <= wr_line;
        end
    end

    assign rd_vld = valid[rd_idx];
    assign rd_tag = tag_ram[rd_idx];
    assign rd_dat = data_ram[rd_idx][rd_off];

endmodule

// File: rtl/icache_param.sv
// Direct-mapped instruction cache between if_pc and if_id with multi-beat bus refill.
// Latency: hits return inst_o in the PC cycle; a miss stalls for the lookup, one cycle per beat, and FILL.
// Backpressure: stall_o holds the fetch stage during refill; bus_stall_i freezes the current beat.
// Ports: pc_i/ce_n_i/flush_i in, inst_o/stall_o out; bus_req_o/bus_addr_o/bus_data_i/bus_stall_i refill bus;
//        hit_cnt_o/miss_cnt_o saturating statistics.
module icache_param
    import icache_param_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_n_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              stall_o,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              bus_stall_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int OFF_W   = clog2(LINE_WORDS);
    localparam int IDX_W   = clog2(LINES);
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W - 2;
    // Single-word lines still need a 1-bit beat/offset vector; it is forced to zero.
    localparam int OFF_SZ  = (OFF_W > 0) ? OFF_W : 1;
    localparam int LINE_SH = OFF_W + 2;

    localparam logic [OFF_SZ-1:0] LAST_BEAT = OFF_SZ'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t                            state, state_nx;
    logic [OFF_SZ-1:0]                 beat;
    logic [ADDR_W-1:0]                 miss_addr;
    logic [LINE_WORDS-1:0][DATA_W-1:0] line_buf;
    logic [LINE_WORDS-1:0][DATA_W-1:0] wr_line;

    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  pc_idx;
    logic [OFF_SZ-1:0] pc_off;
    logic              rd_vld;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_dat;

    logic lookup_en, hit, miss, beat_acc, last_acc;

    assign pc_tag = pc_i[ADDR_W-1 -: TAG_W];
    assign pc_idx = pc_i[LINE_SH +: IDX_W];
    assign pc_off = (OFF_W > 0) ? pc_i[2 +: OFF_SZ] : '0;

    icache_line_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .DATA_W     (DATA_W),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX_W),
        .OFF_SZ     (OFF_SZ)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .rd_idx  (pc_idx),
        .rd_off  (pc_off),
        .rd_vld  (rd_vld),
        .rd_tag  (rd_tag),
        .rd_dat  (rd_dat),
        .wr_en   (last_acc),
        .wr_idx  (miss_addr[LINE_SH +: IDX_W]),
        .wr_tag  (miss_addr[ADDR_W-1 -: TAG_W]),
        .wr_line (wr_line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        lookup_en  = (state == ST_IDLE) && (ce_n_i == CE_ENABLE) && !flush_i;
        hit        = lookup_en && rd_vld && (rd_tag == pc_tag);
        miss       = lookup_en && !hit;
        beat_acc   = (state == ST_REFILL) && !bus_stall_i && !flush_i;
        last_acc   = beat_acc && (beat == LAST_BEAT);
        // The final beat goes straight into the array, bypassing the line buffer.
        wr_line             = line_buf;
        wr_line[LAST_BEAT]  = bus_data_i;

        if (flush_i) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   if (miss)     state_nx = ST_REFILL;
                ST_REFILL: if (last_acc) state_nx = ST_FILL;
                ST_FILL:                 state_nx = ST_IDLE;
                default:                 state_nx = ST_IDLE;
            endcase
        end

        // Outputs are forced low while reset is asserted, independent of the clock.
        // A flush cycle with fetch enabled reports a stall so the PC is retried.
        stall_o    = !rst && ((state != ST_IDLE) || ((ce_n_i == CE_ENABLE) && !hit));
        bus_req_o  = !rst && (state == ST_REFILL);
        bus_addr_o = bus_req_o ? (miss_addr + (ADDR_W'(beat) << 2)) : '0;
        inst_o     = (!rst && hit) ? rd_dat : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat       <= '0;
            miss_addr  <= '0;
            line_buf   <= '0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (flush_i)       beat <= '0;
            else if (beat_acc) beat <= last_acc ? '0 : beat + 1'b1;

            if (beat_acc) line_buf[beat] <= bus_data_i;
            if (miss)     miss_addr      <= pc_i & LINE_MASK;

            if (hit && (hit_cnt_o != CNT_MAX))   hit_cnt_o  <= hit_cnt_o + 1'b1;
            if (miss && (miss_cnt_o != CNT_MAX)) miss_cnt_o <= miss_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_param.sv
// Self-checking bench for icache_param (LINES=16, LINE_WORDS=4).
// Bus returns a deterministic word per address; expectations come from that model.
// Bus stall is driven per-beat by the refill helper.
module tb_icache_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_n_i;
    logic        flush_i;
    logic [31:0] inst_o;
    logic        stall_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_i;
    logic        bus_stall_i;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_hit;
    int exp_miss;

    always #5 clk = ~clk;

    icache_param #(
        .ADDR_W(32), .DATA_W(32), .LINES(16), .LINE_WORDS(4), .CNT_W(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .ce_n_i      (ce_n_i),
        .flush_i     (flush_i),
        .inst_o      (inst_o),
        .stall_o     (stall_o),
        .bus_req_o   (bus_req_o),
        .bus_addr_o  (bus_addr_o),
        .bus_data_i  (bus_data_i),
        .bus_stall_i (bus_stall_i),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    // Memory model: word at 0x40 is 0xA0, each following word one more.
    function automatic logic [31:0] mdl(input logic [31:0] a);
        return 32'hA0 + (((a & ~32'h3) - 32'h40) >> 2);
    endfunction

    always_comb bus_data_i = mdl(bus_addr_o);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, " hit_cnt"},  32'(hit_cnt_o),  32'(exp_hit));
        chk({nm, " miss_cnt"}, 32'(miss_cnt_o), 32'(exp_miss));
    endtask

    // Issue a fetch that must miss, serve the refill, and check the retried hit.
    // Entered and left just after a rising edge; fetch is disabled on return.
    task automatic do_miss(input logic [31:0] a, input int stall_beat, input int stall_n,
                           input int exp_cycles);
        int beat;
        int stalls;
        int cyc;
        bit done;
        beat = 0; stalls = 0; cyc = 0; done = 1'b0;
        pc_i = a; ce_n_i = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (stall_o) begin
                cyc++;
                if (bus_req_o) begin
                    chk($sformatf("bus_addr miss %h beat %0d", a, beat), bus_addr_o,
                        (a & ~32'hF) + 32'(beat * 4));
                    if (beat == stall_beat && stalls < stall_n) begin
                        bus_stall_i = 1'b1;
                        stalls++;
                    end else begin
                        bus_stall_i = 1'b0;
                        beat++;
                    end
                end else begin
                    bus_stall_i = 1'b0;
                end
            end else begin
                done = 1'b1;
            end
        end
        bus_stall_i = 1'b0;
        chk($sformatf("refill completes %h", a), 32'(done), 32'd1);
        chk($sformatf("stall cycles %h", a), 32'(cyc), 32'(exp_cycles));
        chk($sformatf("retry inst %h", a), inst_o, mdl(a));
        exp_miss++;
        exp_hit++;
        @(posedge clk); #1;
        ce_n_i = 1'b0;
        ce_n_i = 1'b1;
        chk_cnt($sformatf("after miss %h", a));
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        ce_n;
        logic [31:0] inst;
        logic        stall;
        int          hits;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // Single-cycle lookups on the 0x40 line once it has been filled.
        tbl[0] = '{pc: 32'h44, ce_n: 1'b0, inst: 32'hA1, stall: 1'b0, hits: 2};
        tbl[1] = '{pc: 32'h48, ce_n: 1'b0, inst: 32'hA2, stall: 1'b0, hits: 3};
        tbl[2] = '{pc: 32'h4C, ce_n: 1'b0, inst: 32'hA3, stall: 1'b0, hits: 4};
        tbl[3] = '{pc: 32'h40, ce_n: 1'b1, inst: 32'h00, stall: 1'b0, hits: 4};
        tbl[4] = '{pc: 32'h4E, ce_n: 1'b0, inst: 32'hA3, stall: 1'b0, hits: 5};
        tbl[5] = '{pc: 32'h42, ce_n: 1'b0, inst: 32'hA0, stall: 1'b0, hits: 6};

        rst = 1'b1; pc_i = 32'h40; ce_n_i = 1'b0; flush_i = 1'b0; bus_stall_i = 1'b0;
        exp_hit = 0; exp_miss = 0;

        // Reset state, with a fetch request present that would otherwise miss.
        #12;
        chk("reset stall_o",    32'(stall_o),    32'd0);
        chk("reset inst_o",     inst_o,          32'd0);
        chk("reset bus_req_o",  32'(bus_req_o),  32'd0);
        chk("reset bus_addr_o", bus_addr_o,      32'd0);
        chk_cnt("reset");
        ce_n_i = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold miss: lookup cycle + 4 beats + FILL.
        do_miss(32'h40, -1, 0, 6);

        for (int i = 0; i < 6; i++) begin
            pc_i = tbl[i].pc; ce_n_i = tbl[i].ce_n;
            @(negedge clk);
            chk($sformatf("vec%0d inst_o", i),  inst_o,          tbl[i].inst);
            chk($sformatf("vec%0d stall_o", i), 32'(stall_o),    32'(tbl[i].stall));
            @(posedge clk); #1;
            chk($sformatf("vec%0d hit_cnt", i), 32'(hit_cnt_o),  32'(tbl[i].hits));
        end
        ce_n_i = 1'b1;
        exp_hit = 6;

        // Bus stall three cycles on beat 2: address must hold at 0x108.
        do_miss(32'h100, 2, 3, 9);

        // Conflict on index 4: 0x140 evicts 0x40, which then misses again.
        do_miss(32'h140, -1, 0, 6);
        do_miss(32'h40, -1, 0, 6);

        // Stalled line still resident with correct contents.
        pc_i = 32'h108; ce_n_i = 1'b0;
        @(negedge clk);
        chk("hit 0x108 inst_o",  inst_o,       32'hD2);
        chk("hit 0x108 stall_o", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        ce_n_i = 1'b1;
        exp_hit++;
        chk_cnt("hit 0x108");

        // Flush during beat 1 of a refill at 0x200.
        pc_i = 32'h200; ce_n_i = 1'b0;
        @(negedge clk);
        chk("flushref lookup stall_o", 32'(stall_o),   32'd1);
        chk("flushref lookup bus_req", 32'(bus_req_o), 32'd0);
        @(negedge clk);
        chk("flushref beat0 addr", bus_addr_o, 32'h200);
        @(negedge clk);
        chk("flushref beat1 addr", bus_addr_o, 32'h204);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; ce_n_i = 1'b1;
        exp_miss++;
        @(negedge clk);
        chk("flushref bus_req after", 32'(bus_req_o), 32'd0);
        chk("flushref stall after",   32'(stall_o),   32'd0);
        chk_cnt("flushref");
        @(posedge clk); #1;
        do_miss(32'h200, -1, 0, 6);
        do_miss(32'h40, -1, 0, 6);

        // Flush in IDLE on a resident line: stalls, returns nothing, not counted.
        pc_i = 32'h204; ce_n_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        chk("idle flush stall_o", 32'(stall_o), 32'd1);
        chk("idle flush inst_o",  inst_o,       32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; ce_n_i = 1'b1;
        chk_cnt("idle flush");
        do_miss(32'h204, -1, 0, 6);

        // Asynchronous reset between edges during a refill.
        pc_i = 32'h300; ce_n_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset bus_req", 32'(bus_req_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async rst stall_o",    32'(stall_o),    32'd0);
        chk("async rst bus_req_o",  32'(bus_req_o),  32'd0);
        chk("async rst bus_addr_o", bus_addr_o,      32'd0);
        chk("async rst inst_o",     inst_o,          32'd0);
        exp_hit = 0; exp_miss = 0;
        chk_cnt("async rst");
        ce_n_i = 1'b1;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        do_miss(32'h40, -1, 0, 6);
        do_miss(32'h200, -1, 0, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
